io_sequencer: RTL and testbench

Run/stall sequencer for the single-cycle CPU's I/O instructions. It sits between the control unit's `OpIn`/`OpOut`/`OpHalt` decodes and the board. It produces the CPU-wide advance enable and holds the CPU on `IN` until the operator confirms the switch value with a debounced push button. It also latches the `OUT` value for the 7-segment driver and freezes the CPU permanently on `HALT` until reset.

---
 rtl/io_sequencer.sv | 88 ++++++++
 tb/tb_io_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/io_sequencer.sv
// io_sequencer: run/stall sequencer for IN/OUT/HALT with debounced confirm button
module io_sequencer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int IN_WIDTH        = 18,
    parameter int OUT_WIDTH       = 28
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 op_in,
    input  logic                 op_out,
    input  logic                 op_halt,
    input  logic                 key_confirm,
    input  logic [IN_WIDTH-1:0]  switches,
    input  logic [OUT_WIDTH-1:0] out_data,
    output logic                 cpu_enable,
    output logic [IN_WIDTH-1:0]  in_value,
    output logic [OUT_WIDTH-1:0] display_value,
    output logic                 out_valid,
    output logic                 waiting_in,
    output logic                 halted
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    typedef enum logic [1:0] {RUN, WAIT_IN, COMMIT_IN, HALTED} state_t;
    state_t state, state_nx;
    logic sync_0, key_sync, key_stable, key_stable_d, confirm_pulse;
    logic [CW-1:0] cnt;
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_0        <= 1'b1;
            key_sync      <= 1'b1;
            key_stable    <= 1'b1;
            key_stable_d  <= 1'b1;
            confirm_pulse <= 1'b0;
            cnt           <= '0;
        end else begin
            sync_0        <= key_confirm;
            key_sync      <= sync_0;
            key_stable_d  <= key_stable;
            confirm_pulse <= key_stable_d & ~key_stable;
            if (key_sync == key_stable)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                key_stable <= key_sync;
                cnt        <= '0;
            end else
                cnt <= cnt + CW'(1);
        end
    end
    always_ff @(posedge clock) begin
        if (!reset_n)
            state <= RUN;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx   = state;
        cpu_enable = 1'b0;
        unique case (state)
            RUN: begin
                cpu_enable = ~op_in & ~op_halt;
                state_nx   = op_halt ? HALTED : op_in ? WAIT_IN : RUN;
            end
            WAIT_IN:   state_nx = confirm_pulse ? COMMIT_IN : WAIT_IN;
            COMMIT_IN: begin
                cpu_enable = 1'b1;
                state_nx   = RUN;
            end
            HALTED:    state_nx = HALTED;
            default:   state_nx = RUN;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            in_value      <= '0;
            display_value <= '0;
            out_valid     <= 1'b0;
        end else begin
            if (state == WAIT_IN && confirm_pulse)
                in_value <= switches;
            if (state == RUN && cpu_enable && op_out) begin
                display_value <= out_data;
                out_valid     <= 1'b1;
            end
        end
    end
    assign waiting_in = (state == WAIT_IN);
    assign halted     = (state == HALTED);
endmodule

// File: tb/tb_io_sequencer.sv
// tb_io_sequencer: directed self-checking bench for io_sequencer (DEBOUNCE_CYCLES=4)
module tb_io_sequencer;
    logic        clock, reset_n, op_in, op_out, op_halt, key_confirm;
    logic [17:0] switches;
    logic [27:0] out_data;
    logic        cpu_enable, out_valid, waiting_in, halted;
    logic [17:0] in_value;
    logic [27:0] display_value;
    int checks = 0;
    int errors = 0;
    int en_cnt;
    io_sequencer #(.DEBOUNCE_CYCLES(4), .IN_WIDTH(18), .OUT_WIDTH(28)) dut (
        .clock(clock), .reset_n(reset_n), .op_in(op_in), .op_out(op_out), .op_halt(op_halt),
        .key_confirm(key_confirm), .switches(switches), .out_data(out_data),
        .cpu_enable(cpu_enable), .in_value(in_value), .display_value(display_value),
        .out_valid(out_valid), .waiting_in(waiting_in), .halted(halted)
    );
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    initial begin
        logic [6:0] bounce;
        reset_n = 1'b0; op_in = 1'b0; op_out = 1'b0; op_halt = 1'b0;
        key_confirm = 1'b1; switches = '0; out_data = '0;
        tick(); tick();
        reset_n = 1'b1;
        #1;
        check("rst_en", cpu_enable, 1);
        check("rst_disp", display_value, 0);
        check("rst_valid", out_valid, 0);
        check("rst_inval", in_value, 0);
        check("rst_wait", waiting_in, 0);
        check("rst_halt", halted, 0);
        op_out = 1'b1; out_data = 28'h1234567;
        #1;
        check("out_en", cpu_enable, 1);
        check("out_disp_before", display_value, 0);
        check("out_valid_before", out_valid, 0);
        tick();
        op_out = 1'b0;
        #1;
        check("out_disp", display_value, 28'h1234567);
        check("out_valid", out_valid, 1);
        op_in = 1'b1; switches = 18'h2A5A3;
        #1;
        check("in_en_run", cpu_enable, 0);
        tick();
        check("in_wait", waiting_in, 1);
        key_confirm = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            check("in_stall_en", cpu_enable, 0);
            check("in_stall_wait", waiting_in, 1);
        end
        tick();
        check("in_commit_en", cpu_enable, 1);
        check("in_value", in_value, 18'h2A5A3);
        check("in_commit_wait", waiting_in, 0);
        tick();
        op_in = 1'b0;
        #1;
        check("in_run_en", cpu_enable, 1);
        check("in_run_wait", waiting_in, 0);
        key_confirm = 1'b1;
        repeat (10) tick();
        op_in = 1'b1;
        tick();
        bounce = 7'b0001000;
        for (int k = 0; k < 7; k++) begin
            key_confirm = bounce[6-k];
            tick();
            check("bounce_wait", waiting_in, 1);
        end
        key_confirm = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("bounce_hold_en", cpu_enable, 0);
            check("bounce_hold_wait", waiting_in, 1);
        end
        switches = 18'h1F00F; key_confirm = 1'b0; en_cnt = 0;
        repeat (12) begin
            tick();
            if (cpu_enable) en_cnt++;
        end
        check("one_pulse_commits", en_cnt, 1);
        check("b2b_rewait", waiting_in, 1);
        check("b2b_inval", in_value, 18'h1F00F);
        en_cnt = 0;
        repeat (10) begin
            tick();
            if (cpu_enable) en_cnt++;
        end
        check("held_no_commit", en_cnt, 0);
        key_confirm = 1'b1;
        repeat (8) begin
            tick();
            if (cpu_enable) en_cnt++;
        end
        check("release_no_commit", en_cnt, 0);
        check("release_wait", waiting_in, 1);
        switches = 18'h00155; key_confirm = 1'b0;
        repeat (7) begin
            tick();
            if (cpu_enable) en_cnt++;
        end
        check("repress_stall", en_cnt, 0);
        tick();
        check("repress_en", cpu_enable, 1);
        check("repress_inval", in_value, 18'h00155);
        tick();
        op_in = 1'b0;
        #1;
        check("repress_run_en", cpu_enable, 1);
        key_confirm = 1'b1;
        repeat (10) tick();
        op_halt = 1'b1; op_in = 1'b1; op_out = 1'b1; out_data = 28'hFFFFFFF;
        #1;
        check("halt_en", cpu_enable, 0);
        tick();
        op_halt = 1'b0; op_in = 1'b0;
        #1;
        check("halt_state", halted, 1);
        check("halt_en2", cpu_enable, 0);
        check("halt_disp", display_value, 28'h1234567);
        check("halt_valid", out_valid, 1);
        en_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            key_confirm = ((i / 7) % 2) != 0;
            tick();
            if (cpu_enable || !halted) en_cnt++;
        end
        check("halt_ignores", en_cnt, 0);
        check("halt_disp_end", display_value, 28'h1234567);
        key_confirm = 1'b1; reset_n = 1'b0;
        tick();
        reset_n = 1'b1; op_out = 1'b0;
        #1;
        check("halt_rst_state", halted, 0);
        check("halt_rst_en", cpu_enable, 1);
        check("halt_rst_disp", display_value, 0);
        check("halt_rst_valid", out_valid, 0);
        check("halt_rst_inval", in_value, 0);
        check("halt_rst_wait", waiting_in, 0);
        op_in = 1'b1; switches = 18'h3FFFF;
        tick();
        check("mid_wait", waiting_in, 1);
        key_confirm = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0; key_confirm = 1'b1;
        tick();
        reset_n = 1'b1;
        #1;
        check("mid_rst_wait", waiting_in, 0);
        check("mid_rst_inval", in_value, 0);
        check("mid_rst_en", cpu_enable, 0);
        en_cnt = 0;
        repeat (15) begin
            tick();
            if (cpu_enable) en_cnt++;
        end
        check("mid_rst_no_pulse", en_cnt, 0);
        check("mid_rst_rewait", waiting_in, 1);
        check("mid_rst_inval2", in_value, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
